// File: rtl/fp_expand_seq_if.sv
// fp_expand_seq_if
//   Handshake bundle between an FPCVT producer, the fp_expand_seq rebuilder
//   and the downstream consumer of the reconstructed word.
//   in_valid/in_ready : input triple handshake
//   in_s/in_e/in_f    : sign, exponent, significand of the triple
//   out_valid/out_ready: result handshake
//   out_d             : reconstructed two's-complement value
//   master: drives the triple and out_ready (upstream/downstream side)
//   slave : the rebuilder itself
interface fp_expand_seq_if #(
    parameter int unsigned D_WIDTH = 12,
    parameter int unsigned E_WIDTH = 3,
    parameter int unsigned F_WIDTH = 4
);
    logic               in_valid;
    logic               in_ready;
    logic               in_s;
    logic [E_WIDTH-1:0] in_e;
    logic [F_WIDTH-1:0] in_f;
    logic               out_valid;
    logic               out_ready;
    logic [D_WIDTH-1:0] out_d;

    modport master (
        output in_valid, in_s, in_e, in_f, out_ready,
        input  in_ready, out_valid, out_d
    );

    modport slave (
        input  in_valid, in_s, in_e, in_f, out_ready,
        output in_ready, out_valid, out_d
    );
endinterface

// File: rtl/fp_expand_seq.sv
// fp_expand_seq
//   Rebuilds (-1)^S * F * 2^E from an FPCVT triple as a D_WIDTH-bit
//   two's-complement word, shifting the magnitude one bit per cycle.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, aborts any conversion in flight
//   bus : fp_expand_seq_if slave (input triple handshake, result handshake)
module fp_expand_seq #(
    parameter int unsigned D_WIDTH = 12,
    parameter int unsigned E_WIDTH = 3,
    parameter int unsigned F_WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    fp_expand_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [D_WIDTH-1:0] mag;
    logic [E_WIDTH-1:0] cnt;
    logic               sign;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [D_WIDTH-1:0] out_d_q;
    logic               accept;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_d     = out_d_q;

    assign accept = bus.in_valid && in_ready_q;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (cnt == '0) state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // in_ready/out_valid are registered from the next state so they are
    // glitch-free and track IDLE/DONE exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_d_q     <= '0;
            mag         <= '0;
            cnt         <= '0;
            sign        <= 1'b0;
        end else begin
            state       <= state_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        mag  <= {{(D_WIDTH-F_WIDTH){1'b0}}, bus.in_f};
                        cnt  <= bus.in_e;
                        sign <= bus.in_s;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        mag <= mag << 1;
                        cnt <= cnt - E_WIDTH'(1);
                    end else begin
                        // Negating zero yields zero, so S=1,F=0 never gives -0.
                        out_d_q <= sign ? (~mag + D_WIDTH'(1)) : mag;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
